// File: rtl/wb_scoreboard.sv
// wb_scoreboard: write-back scoreboard for the register-file write port.
// Expected (register, value) pairs are preloaded into a circular queue; once
// started, every architectural write (wb_we with a non-zero address) is checked
// against the queue head. Reports pass/fail, the failing entry and the cause.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   clr              synchronous flush back to IDLE with an empty queue
//   start            begin checking (honoured in IDLE only)
//   exp_valid/ready  expected-entry push handshake, exp_addr/exp_data payload
//   wb_we/waddr/wdata  tapped register-file write port
//   busy/done/pass/fail  status decoded from the state register
//   fail_code        0 none, 1 address mismatch, 2 data mismatch, 3 timeout
//   match_cnt        matched writes since start (saturating)
//   err_addr/exp/got captured failing write and expected head data
module wb_scoreboard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [REG_AW-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [15:0]       match_cnt,
  output logic [REG_AW-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t            state;
  logic [REG_AW-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [TO_W-1:0]   to_cnt;

  logic              empty;
  logic              full;
  logic              push;
  logic [REG_AW-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              chk_wr;
  logic              addr_bad;
  logic              data_bad;
  logic              hit;
  logic              to_fire;
  logic              last_pop;

  // Queue status from the extra pointer MSB: equal pointers are empty,
  // same index with differing MSB is full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  assign exp_ready = !full && ((state == S_IDLE) || (state == S_RUN));
  assign push      = exp_valid && exp_ready;

  assign head_addr = mem_addr[rd_ptr[IW-1:0]];
  assign head_data = mem_data[rd_ptr[IW-1:0]];

  // Only non-r0 writes in RUN are checked; address mismatch outranks data.
  assign chk_wr   = wb_we && (wb_waddr != '0) && (state == S_RUN);
  assign addr_bad = chk_wr && (wb_waddr != head_addr);
  assign data_bad = chk_wr && !addr_bad && (wb_wdata != head_data);
  assign hit      = chk_wr && !addr_bad && !data_bad;

  // A checked write in the same cycle suppresses the timeout.
  assign to_fire = (state == S_RUN) && !chk_wr && (to_cnt == TO_W'(TIMEOUT - 1));

  // The queue drains on this hit unless a new entry lands in the same cycle.
  assign last_pop = hit && !push && (wr_ptr == rd_ptr + PW'(1));

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[IW-1:0]] <= exp_addr;
      mem_data[wr_ptr[IW-1:0]] <= exp_data;
    end
  end

  // Control state, pointers, timeout counter and result capture.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      to_cnt    <= '0;
      fail_code <= 2'd0;
      match_cnt <= 16'd0;
      err_addr  <= '0;
      err_exp   <= '0;
      err_got   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            match_cnt <= 16'd0;
            to_cnt    <= '0;
            state     <= empty ? S_PASS : S_RUN;
          end
        end
        S_RUN: begin
          if (addr_bad || data_bad) begin
            state     <= S_FAIL;
            fail_code <= addr_bad ? 2'd1 : 2'd2;
            err_addr  <= wb_waddr;
            err_exp   <= head_data;
            err_got   <= wb_wdata;
          end else if (hit) begin
            rd_ptr <= rd_ptr + PW'(1);
            to_cnt <= '0;
            if (match_cnt != 16'hFFFF) begin
              match_cnt <= match_cnt + 16'd1;
            end
            if (last_pop) begin
              state <= S_PASS;
            end
          end else if (to_fire) begin
            state     <= S_FAIL;
            fail_code <= 2'd3;
            err_addr  <= '0;
            err_exp   <= head_data;
            err_got   <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Synthesizable write-back scoreboard for the OpenMIPS min-SOPC. It taps the register-file write port and checks every architectural register write against a preloaded stream of expected (register, value) pairs. It generalises the per-cycle register assertions of the instruction-class benches into one parametrised block. Register count, data width, queue depth and timeout are configurable, and the block reports pass/fail, the failing entry and the failure cause in hardware.

## Interface
Parameters:
- DATA_W, 32, register data width
- REG_AW, 5, register address width (2^REG_AW registers)
- DEPTH, 16, expected-entry queue depth; must be a power of two, ≥2
- TO_W, 8, timeout counter width
- TIMEOUT, 100, idle cycles allowed in RUN with no checked write; 1..2^TO_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- clr  in  1  synchronous flush: queue emptied, state→IDLE, counters/error fields zeroed
- start  in  1  begin checking; honoured only in IDLE
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  queue accepts entry; equals !full && (state==IDLE || state==RUN)
- exp_addr  in  REG_AW  expected destination register
- exp_data  in  DATA_W  expected written value
- wb_we  in  1  register-file write enable
- wb_waddr  in  REG_AW  register-file write address
- wb_wdata  in  DATA_W  register-file write data
- busy  out  1  state==RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state==PASS
- fail  out  1  state==FAIL
- fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- match_cnt  out  16  writes matched since start (saturates at 16'hFFFF)
- err_addr  out  REG_AW  observed wb_waddr at failure (0 on timeout)
- err_exp  out  DATA_W  expected data at queue head at failure
- err_got  out  DATA_W  observed wb_wdata at failure (0 on timeout)

## Operation
- States: IDLE, RUN, PASS, FAIL.
  - IDLE: start → RUN (queue non-empty) or PASS (queue empty).
  - RUN: match popping last entry → PASS; mismatch or timeout → FAIL.
  - PASS and FAIL: sticky until clr or reset.
- Queue: circular buffer, read/write pointers REG-width log2(DEPTH)+1. Full and empty are derived from the MSB-differing pointer compare, and wrap-around is by natural overflow.
- Push occurs when exp_valid && exp_ready. In RUN, a push and a pop in the same cycle leave the occupancy unchanged.
- Checked write: wb_we && wb_waddr != 0 && state==RUN. Writes to r0 and writes outside RUN are ignored and do not touch the timeout counter.
- Compare against the queue head:
  - Address differs → FAIL, code 1.
  - Address equal, data differs → FAIL, code 2.
  - Both equal → pop, match_cnt+1.
- Address mismatch takes priority over data mismatch.
- Timeout: the counter clears on start and on every checked write, and increments each other RUN cycle. Reaching TIMEOUT → FAIL, code 3.
- A checked write in the same cycle the timeout would fire takes priority; the timeout does not fire that cycle.
- clr asserted together with start: clr wins, state→IDLE.
- Reset overrides clr and start.

## Timing
- Reset values (rst low at an edge): state IDLE, queue empty, exp_ready=1, busy/done/pass/fail=0, fail_code=0, match_cnt=0, err_* =0, timeout counter 0.
- All outputs are registered or decoded from registered state. There is no combinational path from wb_* to any output.
- A write sampled at edge N is reflected in pass/fail/match_cnt/err_* immediately after edge N.
- start sampled at edge N → busy high after edge N.
- After FAIL, err_* and fail_code are frozen. Later writes change nothing.
- Reset mid-RUN: at the next edge all state is cleared and the queue contents are discarded.

## Test plan
- Logic-sequence pass: preload (1,01010000),(1,01010101),(2,01011101),(1,01011101),(3,00000000),(1,00000000),(4,0000FF00),(1,0000FF00),(1,FFFF00FF), start, drive the same writes one per cycle → pass=1 one edge after the ninth write, match_cnt=9, fail_code=0.
- Data mismatch: same preload, third write (2,01011100) → fail=1, fail_code=2, err_addr=2, err_exp=01011101, err_got=01011100, match_cnt=2. Later writes leave these fields frozen.
- Address mismatch plus r0 filter: expect (4,0000FF00). Write (0,DEADBEEF) → ignored. Write (3,0000FF00) → fail_code=1, err_addr=3.
- Timeout, TIMEOUT=5: one entry loaded, start, no writes → fail, fail_code=3, exactly 5 cycles after busy rose. Repeat with a r0 write at cycle 3 → still fails at cycle 5.
- Full/wrap with DEPTH=4:
  - Load 4 entries; exp_ready=0 on the 5th offer.
  - In RUN, push one entry per matched pop over 10 entries (pointers wrap twice) → pass, match_cnt=10.
- Empty start / clr / reset: start with an empty queue → pass after one edge. Assert clr → IDLE, flags 0. Pull rst low mid-RUN → all outputs return to their reset values after one edge.
